squeeze_serializer: RTL and testbench

Transmit-side counterpart of the absorb-path message accumulator. It takes RATE_BITS-wide squeezed blocks from the Keccak core and emits the requested number of SHAKE256 output bits as 2-bit chunks under a valid/ready handshake. When a block is exhausted and more output is still needed, it requests the next permutation. Bit ordering matches the absorb path: byte j is block[8j+:8], LSB-first within each byte. Chunk k of a block is therefore block[2k+:2].

---
 rtl/squeeze_serializer.sv | 76 +++++++
 tb/tb_squeeze_serializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/squeeze_serializer.sv
// squeeze_serializer: streams SHAKE256 squeeze output as 2-bit chunks, requesting a permutation between rate blocks
// Ports: start/out_bits launch a job (length in bits, bit 0 ignored); block_valid/block_data/block_ack load a rate block;
//   request_permute asks control for the next block; serial_out/serial_valid/serial_ready/serial_last carry the chunk
//   stream (chunk k of a block is block[2k+:2]); busy is high outside idle; done pulses once per job.
module squeeze_serializer #(
  parameter int RATE_BITS = 1088,
  parameter int OUT_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OUT_LEN_W-1:0] out_bits,
  input  logic                 block_valid,
  input  logic [RATE_BITS-1:0] block_data,
  output logic                 block_ack,
  output logic                 request_permute,
  output logic [1:0]           serial_out,
  output logic                 serial_valid,
  input  logic                 serial_ready,
  output logic                 serial_last,
  output logic                 busy,
  output logic                 done
);
  localparam logic [10:0] LAST_IDX = 11'(RATE_BITS / 2 - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT_BLK, ST_SHIFT, ST_REQ, ST_DONE} state_t;
  state_t r_state, w_next;
  logic [RATE_BITS-1:0] r_shreg;
  logic [OUT_LEN_W-1:0] r_remaining, w_len;
  logic [10:0] r_cidx;
  logic w_xfer, w_last;
  assign w_len = out_bits >> 1;
  assign w_xfer = (r_state == ST_SHIFT) & serial_ready;
  assign w_last = r_remaining == OUT_LEN_W'(1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     w_next = start ? ((w_len == '0) ? ST_DONE : ST_WAIT_BLK) : ST_IDLE;
      ST_WAIT_BLK: w_next = block_valid ? ST_SHIFT : ST_WAIT_BLK;
      // finishing the job outranks the end-of-block permute request
      ST_SHIFT:    w_next = !w_xfer ? ST_SHIFT : w_last ? ST_DONE : (r_cidx == LAST_IDX) ? ST_REQ : ST_SHIFT;
      ST_REQ:      w_next = ST_WAIT_BLK;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end
  assign block_ack       = (r_state == ST_WAIT_BLK) & block_valid;
  assign request_permute = r_state == ST_REQ;
  assign serial_valid    = r_state == ST_SHIFT;
  assign serial_out      = r_shreg[1:0];
  assign serial_last     = serial_valid & w_last;
  assign busy            = r_state != ST_IDLE;
  assign done            = r_state == ST_DONE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shreg     <= '0;
      r_remaining <= '0;
      r_cidx      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start) begin
        r_remaining <= w_len;
        r_cidx      <= '0;
      end
      if (block_ack) begin
        r_shreg <= block_data;
        r_cidx  <= '0;
      end
      if (w_xfer) begin
        r_shreg     <= r_shreg >> 2;
        r_remaining <= r_remaining - OUT_LEN_W'(1);
        r_cidx      <= r_cidx + 11'd1;
      end
    end
  end
endmodule

// File: tb/tb_squeeze_serializer.sv
// tb_squeeze_serializer: scoreboard bench for squeeze_serializer
module tb_squeeze_serializer;
  localparam int RB = 1088;
  localparam int CPB = RB / 2;
  logic clk = 0, reset = 0, start = 0, block_valid = 1, serial_ready = 1;
  logic [15:0] out_bits = '0;
  logic [RB-1:0] block_data, blk0, blk1;
  logic block_ack, request_permute, serial_valid, serial_last, busy, done;
  logic [1:0] serial_out;
  typedef struct {logic [1:0] d; logic l;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  int n_ack = 0, n_req = 0, n_done = 0, n_valid = 0, n_beat = 0;
  int req_base = 0, beat_base = 0, stall_at = 0, job_id = 0, stalled_job = 0, stall_cnt = 0;
  always #5 clk = ~clk;
  assign block_data = (n_req == req_base) ? blk0 : blk1;
  squeeze_serializer #(.RATE_BITS(RB), .OUT_LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .out_bits(out_bits),
    .block_valid(block_valid), .block_data(block_data), .block_ack(block_ack),
    .request_permute(request_permute), .serial_out(serial_out), .serial_valid(serial_valid),
    .serial_ready(serial_ready), .serial_last(serial_last), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      n_ack += int'(block_ack);
      n_req += int'(request_permute);
      n_done += int'(done);
      n_valid += int'(serial_valid);
      if (serial_valid) begin
        if (q.size() == 0) check("extra_beat", 32'd1, 32'd0);
        else begin
          check("chunk", {29'd0, serial_out, serial_last}, {29'd0, q[0].d, q[0].l});
          if (serial_ready) begin
            void'(q.pop_front());
            n_beat++;
          end
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      stall_cnt--;
      if (stall_cnt == 0) serial_ready = 1;
    end else if (stall_at > 0 && stalled_job != job_id && n_beat - beat_base == stall_at) begin
      serial_ready = 0;
      stall_cnt = 3;
      stalled_job = job_id;
    end
  end
  function automatic logic [RB-1:0] rnd_blk();
    logic [RB-1:0] b;
    for (int i = 0; i < RB / 32; i++) b[32*i+:32] = $urandom;
    return b;
  endfunction
  task automatic push_exp(input int n);
    logic [RB-1:0] b;
    for (int k = 0; k < n; k++) begin
      b = (k / CPB == 0) ? blk0 : blk1;
      q.push_back('{d: b[2*(k%CPB)+:2], l: (k == n - 1)});
    end
  endtask
  task automatic pulse_start(input logic [15:0] ob);
    @(negedge clk);
    out_bits = ob;
    start = 1;
    req_base = n_req;
    beat_base = n_beat;
    @(negedge clk);
    start = 0;
    #1;
  endtask
  task automatic run_job(input logic [15:0] ob, input int stall, input bit poke);
    int n, a0, r0, d0, v0, cyc, nb;
    n = int'(ob >> 1);
    a0 = n_ack; r0 = n_req; d0 = n_done; v0 = n_valid;
    nb = (n + CPB - 1) / CPB;
    stall_at = stall;
    job_id++;
    push_exp(n);
    pulse_start(ob);
    cyc = 1;
    while (n_done == d0 && cyc < 5000) begin
      if (poke && cyc == 10) begin start = 1; out_bits = 16'd0; end
      if (poke && cyc == 11) start = 0;
      @(negedge clk);
      #1;
      cyc++;
    end
    check("done_count", n_done - d0, 1);
    check("queue_empty", q.size(), 0);
    check("ack_count", n_ack - a0, nb);
    check("req_count", n_req - r0, (nb > 0) ? nb - 1 : 0);
    if (n == 0) begin
      check("done_latency", cyc, 1);
      check("no_valid", n_valid - v0, 0);
    end
    @(negedge clk);
    #1;
    check("idle_busy", {31'd0, busy}, 0);
    check("idle_done", {31'd0, done}, 0);
    q.delete();
  endtask
  task automatic check_outs_zero(input string tag);
    check(tag, {24'd0, block_ack, request_permute, serial_out, serial_valid, serial_last, busy, done}, 0);
  endtask
  initial begin
    blk0 = '0;
    blk1 = '0;
    repeat (3) @(negedge clk);
    check_outs_zero("por_outputs");
    reset = 1;
    @(negedge clk);
    blk0 = rnd_blk(); blk0[7:0] = 8'hA7;
    run_job(16'd8, 0, 0);
    blk0 = rnd_blk();
    run_job(16'd1088, 0, 1);
    blk0 = rnd_blk(); blk1 = rnd_blk(); blk1[7:0] = 8'h1B;
    run_job(16'd1096, 0, 0);
    blk0 = rnd_blk();
    run_job(16'd16, 2, 0);
    run_job(16'd0, 0, 0);
    run_job(16'd1, 0, 0);
    begin
      int cyc;
      blk0 = rnd_blk();
      job_id++;
      stall_at = 0;
      push_exp(544);
      pulse_start(16'd1088);
      cyc = 0;
      while (n_beat - beat_base < 100 && cyc < 3000) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check("reach_beat100", {31'd0, n_beat - beat_base >= 100}, 1);
      @(posedge clk);
      #2;
      reset = 0;
      #1;
      check_outs_zero("reset_async");
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check_outs_zero("reset_hold");
      end
      q.delete();
      reset = 1;
      @(negedge clk);
    end
    blk0 = rnd_blk(); blk0[7:0] = 8'hA7;
    run_job(16'd8, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
